// File: rtl/dm_uart_pkg.sv
// Shared UART definitions for the DM serial link (receive and transmit sides).
package dm_uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  // 100 MHz system clock / 115200 baud
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; reset value lets an idle-high line start out idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronises the pad, samples mid-bit, and hands bytes
// to the command parser through a one-entry valid/ready holding register.
module uart_rx_deser
  import dm_uart_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_pad,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] T_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          timer_q, timer_d;
  logic [IDX_W-1:0]          idx_q,   idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q,  data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q,  ferr_d;
  logic                      ovr_q,   ovr_d;
  logic                      byte_done;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_pad),
    .q_o (rx_s)
  );

  // State, datapath and holding-register registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Bit-timing FSM plus holding-register load/overrun decision.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    byte_done = 1'b0;

    if (valid_q && rx_ready) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (timer_q == T_LAST) begin
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          timer_d = '0;
          if (idx_q == I_LAST) state_d = STOP;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A completed byte loads if the slot is empty or being drained this cycle.
    if (byte_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
module tb_uart_rx_deser;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pad = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  int vld_cycles = 0;

  uart_rx_deser #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_pad    (rx_pad),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: sampled on the falling edge, records handshakes and pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid) vld_cycles++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    rx_pad = lvl;
    tick(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_lvl, CPB);
    rx_pad = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_pad = 1'b1;
    tick(3);
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data got %h want 00", rx_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_ovr got %b want 0", overrun); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_basic();
    int fe0, ov0, v0;
    logic [7:0] e, g;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cycles;
    rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    tick(CPB);
    tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL basic_count got %0d want 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL basic_data got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    tests_run++; if (vld_cycles - v0 != 1) begin tests_failed++; $display("FAIL basic_valid_len got %0d want 1", vld_cycles - v0); end
    tests_run++; if (fe_cnt != fe0) begin tests_failed++; $display("FAIL basic_ferr got %0d want %0d", fe_cnt, fe0); end
    tests_run++; if (ov_cnt != ov0) begin tests_failed++; $display("FAIL basic_ovr got %0d want %0d", ov_cnt, ov0); end
  endtask

  task automatic test_glitch();
    int fe0;
    logic seen;
    fe0 = fe_cnt;
    seen = 1'b0;
    rx_pad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) rx_pad = 1'b1;
      tick(1);
      if (busy) seen = 1'b1;
    end
    tick(10);
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL glitch_busy_rise got %b want 1", seen); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_end got %b want 0", busy); end
    tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL glitch_no_valid got %0d want 0", got_q.size()); end
    tests_run++; if (fe_cnt != fe0) begin tests_failed++; $display("FAIL glitch_ferr got %0d want %0d", fe_cnt, fe0); end
    got_q.delete();
  endtask

  task automatic test_frame_err();
    int fe0;
    logic [7:0] e, g;
    fe0 = fe_cnt;
    send_byte(8'hA3, 1'b0);
    hold(1'b0, 40 - CPB);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ferr_busy_low got %b want 1", busy); end
    tests_run++; if (fe_cnt - fe0 != 1) begin tests_failed++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - fe0); end
    tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL ferr_no_valid got %0d want 0", got_q.size()); end
    hold(1'b1, 5);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ferr_busy_high got %b want 0", busy); end
    got_q.delete();
    hold(1'b1, 15);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    tick(CPB);
    tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL ferr_next_count got %0d want 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL ferr_next_data got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overrun();
    int ov0, fe0;
    logic [7:0] e, g;
    ov0 = ov_cnt; fe0 = fe_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    hold(1'b1, 4);
    send_byte(8'h22, 1'b1);
    tick(CPB);
    tests_run++; if (rx_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid_held got %b want 1", rx_valid); end
    tests_run++; if (rx_data !== 8'h11) begin tests_failed++; $display("FAIL ovr_data_held got %h want 11", rx_data); end
    tests_run++; if (ov_cnt - ov0 != 1) begin tests_failed++; $display("FAIL ovr_pulses got %0d want 1", ov_cnt - ov0); end
    tests_run++; if (fe_cnt != fe0) begin tests_failed++; $display("FAIL ovr_ferr got %0d want %0d", fe_cnt, fe0); end
    rx_ready = 1'b1;
    tick(3);
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_valid_clear got %b want 0", rx_valid); end
    tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL ovr_count got %0d want 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL ovr_data got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, g;
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    tick(CPB);
    tests_run++; if (got_q.size() != 2) begin tests_failed++; $display("FAIL b2b_count got %0d want 2", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL b2b_data got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    int fe0, ov0;
    logic [7:0] e, g;
    logic [7:0] b;
    fe0 = fe_cnt; ov0 = ov_cnt;
    b = 8'hC3;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(b[i], CPB);
    hold(b[4], CPB / 2);
    rst = 1'b1;
    rx_pad = 1'b1;
    tick(3);
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid got %b want 0", rx_valid); end
    tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_data got %h want 00", rx_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tests_run++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin tests_failed++; $display("FAIL rstmid_pulses got %b%b want 00", frame_err, overrun); end
    rst = 1'b0;
    hold(1'b1, 40);
    tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL rstmid_no_output got %0d want 0", got_q.size()); end
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    tick(CPB);
    tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL rstmid_count got %0d want 1", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL rstmid_data_rx got %h want %h", g, e); end
    end
    tests_run++; if (fe_cnt != fe0 || ov_cnt != ov0) begin tests_failed++; $display("FAIL rstmid_errs got fe=%0d ov=%0d want fe=%0d ov=%0d", fe_cnt, ov_cnt, fe0, ov0); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    tests_run++; if (both_cnt != 0) begin tests_failed++; $display("FAIL ferr_ovr_exclusive got %0d want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
